// File: rtl/fnd_pkg.sv
// Shared definitions for the FND display path: converter state encoding and BCD limits.
package fnd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } fnd_state_t;

    localparam int BCD_MAX     = 9999;
    localparam int BCD_DIGIT_W = 4;

endpackage

// File: rtl/bcd_add3.sv
// One BCD nibble correction step of shift-and-add-3: values of 5 or more get +3
// so that the following left shift carries correctly into the next decade.
module bcd_add3
    import fnd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    // Pure combinational nibble correction
    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).
// A conversion takes BIN_W shift cycles followed by a one-cycle done pulse; the
// digit outputs hold the last result until the next done.
// Optional build macro BCD_SAT_EN: inputs above 9999 saturate to 9999 and raise
// overflow. Without it the thousands carry is simply dropped (result mod 10000)
// and overflow is tied low. Latency is the same in both builds.
module bin2bcd_seq
    import fnd_pkg::*;
#(
    parameter int BIN_W    = 14,
    parameter int N_DIGITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [3:0]       digit_1,
    output logic [3:0]       digit_10,
    output logic [3:0]       digit_100,
    output logic [3:0]       digit_1000,
    output logic             overflow
);

    localparam int BCD_W = N_DIGITS * BCD_DIGIT_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    fnd_state_t       state, state_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic [BIN_W-1:0] shreg;
    logic [BCD_W-1:0] bcd, bcd_adj, bcd_nxt;
    logic             accept;
    logic             last_shift;

    assign accept     = start && (state == ST_IDLE || state == ST_DONE);
    assign last_shift = (state == ST_SHIFT) && (bit_cnt == CNT_W'(1));

    // Per-decade add-3 correction applied before every shift
    for (genvar g = 0; g < N_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (bcd[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dout (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Shift the corrected accumulator left, pulling in the next binary MSB; the bit
    // leaving the thousands nibble falls off through the width cast
    assign bcd_nxt = BCD_W'({bcd_adj, shreg[BIN_W-1]});

    // Next-state logic: accept from IDLE/DONE, finish after the last shift
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (bit_cnt == CNT_W'(1)) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = start ? ST_SHIFT : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register and bit counter; reset aborts any running conversion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                bit_cnt <= CNT_W'(BIN_W);
            end else if (state == ST_SHIFT) begin
                bit_cnt <= bit_cnt - CNT_W'(1);
            end
        end
    end

    // Working shift register and accumulator; only meaningful while SHIFT, so no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            shreg <= bin;
            bcd   <= '0;
        end else if (state == ST_SHIFT) begin
            shreg <= {shreg[BIN_W-2:0], 1'b0};
            bcd   <= bcd_nxt;
        end
    end

`ifdef BCD_SAT_EN
    logic ovf_lat;

    // Range check is done once on the latched input value
    always_ff @(posedge clk) begin
        if (accept) begin
            ovf_lat <= (int'(bin) > BCD_MAX);
        end
    end

    // Output registers load on the edge that raises done; saturate when out of range
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {digit_1000, digit_100, digit_10, digit_1} <= '0;
            overflow <= 1'b0;
        end else if (last_shift) begin
            if (ovf_lat) begin
                {digit_1000, digit_100, digit_10, digit_1} <= 16'h9999;
                overflow <= 1'b1;
            end else begin
                {digit_1000, digit_100, digit_10, digit_1} <= bcd_nxt;
                overflow <= 1'b0;
            end
        end
    end
`else
    assign overflow = 1'b0;

    // Output registers load on the edge that raises done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {digit_1000, digit_100, digit_10, digit_1} <= '0;
        end else if (last_shift) begin
            {digit_1000, digit_100, digit_10, digit_1} <= bcd_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: timeline-based reference model plus
// directed vectors with hand-computed expectations.
module tb_bin2bcd_seq;

    localparam int BIN_W = 14;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [BIN_W-1:0] bin;
    logic             busy, done, overflow;
    logic [3:0]       digit_1, digit_10, digit_100, digit_1000;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: edge counter, accepted conversion, expected held outputs
    int          edge_n    = 0;
    bit          m_active  = 1'b0;
    int          m_acc     = 0;
    int          m_bin     = 0;
    logic [15:0] m_dig     = 16'h0;
    logic        m_ovf     = 1'b0;
    int          done_cnt  = 0;
    int          busy_cnt  = 0;
    int          last_done_edge = -1;

    bin2bcd_seq #(.BIN_W(BIN_W), .N_DIGITS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bin        (bin),
        .busy       (busy),
        .done       (done),
        .digit_1    (digit_1),
        .digit_10   (digit_10),
        .digit_100  (digit_100),
        .digit_1000 (digit_1000),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        int x;
`ifdef BCD_SAT_EN
        x = (v > 9999) ? 9999 : v;
`else
        x = v % 10000;
`endif
        return {4'((x / 1000) % 10), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
    endfunction

    function automatic logic exp_ovf(input int v);
`ifdef BCD_SAT_EN
        return v > 9999;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model advanced on each clock edge, then outputs compared 1 time unit later
    always @(posedge clk) begin
        bit prev_busy, e_busy, e_done;
        edge_n++;
        if (reset) begin
            m_active = 1'b0;
            m_dig    = 16'h0;
            m_ovf    = 1'b0;
        end else begin
            prev_busy = m_active && (edge_n - 1 >= m_acc) && (edge_n - 1 < m_acc + BIN_W);
            if (m_active && edge_n == m_acc + BIN_W) begin
                m_dig = to_bcd(m_bin);
                m_ovf = exp_ovf(m_bin);
            end
            if (start && !prev_busy) begin
                m_active = 1'b1;
                m_acc    = edge_n;
                m_bin    = int'(bin);
            end
        end
        e_busy = m_active && (edge_n >= m_acc) && (edge_n < m_acc + BIN_W);
        e_done = m_active && (edge_n == m_acc + BIN_W);
        #1;
        if (!reset) begin
            check("busy", int'(busy), int'(e_busy));
            check("done", int'(done), int'(e_done));
            check("digits", int'({digit_1000, digit_100, digit_10, digit_1}), int'(m_dig));
            check("overflow", int'(overflow), int'(m_ovf));
            if (done === 1'b1) begin
                done_cnt++;
                last_done_edge = edge_n;
            end
            if (busy === 1'b1) busy_cnt++;
        end
    end

    // Wait (bounded) for a done pulse; returns the edge index at which it appeared
    task automatic wait_done(input string name, output int at_edge);
        bit found = 1'b0;
        at_edge = -1;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #2;
            if (done === 1'b1) begin
                found   = 1'b1;
                at_edge = edge_n;
            end
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL %s: no done within 40 cycles, got none, expected one", name);
        end
    endtask

    // Launch one conversion with a single-cycle start pulse; returns accepting edge
    task automatic pulse_start(input int value, output int acc_edge);
        @(negedge clk);
        bin      = BIN_W'(value);
        start    = 1'b1;
        acc_edge = edge_n + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    function automatic int dig16();
        return int'({digit_1000, digit_100, digit_10, digit_1});
    endfunction

    initial begin
        int a, d, dc;
        reset = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_digits", dig16(), 0);
        check("reset_overflow", int'(overflow), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 1234: latency and busy length
        busy_cnt = 0;
        pulse_start(1234, a);
        wait_done("t1234_done", d);
        check("t1234_latency", d - a, 14);
        check("t1234_busy_cycles", busy_cnt, 14);
        check("t1234_digits", dig16(), 'h1234);
        check("t1234_overflow", int'(overflow), 0);

        // 0 then 9999
        pulse_start(0, a);
        wait_done("t0_done", d);
        check("t0_digits", dig16(), 'h0000);
        check("t0_overflow", int'(overflow), 0);
        pulse_start(9999, a);
        wait_done("t9999_done", d);
        check("t9999_digits", dig16(), 'h9999);
        check("t9999_overflow", int'(overflow), 0);

        // 12345: saturate or wrap depending on build
        pulse_start(12345, a);
        wait_done("t12345_done", d);
`ifdef BCD_SAT_EN
        check("t12345_digits", dig16(), 'h9999);
        check("t12345_overflow", int'(overflow), 1);
`else
        check("t12345_digits", dig16(), 'h2345);
        check("t12345_overflow", int'(overflow), 0);
`endif

        // start during conversion is ignored
        repeat (2) @(negedge clk);
        dc = done_cnt;
        pulse_start(1234, a);
        repeat (3) @(negedge clk);
        bin   = BIN_W'(5678);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("tign_done", d);
        check("tign_latency", d - a, 14);
        check("tign_digits", dig16(), 'h1234);
        repeat (20) @(negedge clk);
        check("tign_done_count", done_cnt - dc, 1);

        // reset mid-conversion aborts
        dc = done_cnt;
        pulse_start(4321, a);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("tabort_busy", int'(busy), 0);
        check("tabort_digits", dig16(), 0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("tabort_no_done", done_cnt - dc, 0);
        pulse_start(4321, a);
        wait_done("tabort_redo_done", d);
        check("tabort_redo_digits", dig16(), 'h4321);

        // back-to-back with start held high
        repeat (2) @(negedge clk);
        bin   = BIN_W'(42);
        start = 1'b1;
        a     = edge_n + 1;
        wait_done("tb2b_first_done", d);
        check("tb2b_first_at", d - a, 14);
        check("tb2b_first_digits", dig16(), 'h0042);
        @(negedge clk);
        bin = BIN_W'(100);
        wait_done("tb2b_second_done", d);
        check("tb2b_second_at", d - a, 29);
        check("tb2b_second_digits", dig16(), 'h0100);
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("tb2b_hold_digits", dig16(), 'h0100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
